// File: rtl/correlator_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : correlator_pkg
//  Purpose  : Shared types, constants and sizing helpers for the correlator
//             frame path (frame state encoding, header default, frame sizes).
//  Revision : 1.0  initial release
// ============================================================================
package correlator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_SEQ  = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4
  } frame_state_t;

  localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;

  // Number of bytes used to carry one count on the wire.
  function automatic int bytes_per_count(input int resolution);
    return resolution / 8;
  endfunction

  // Header + sequence + payload + checksum.
  function automatic int frame_length(input int num_channels, input int resolution);
    return 3 + num_channels * bytes_per_count(resolution);
  endfunction

endpackage
`default_nettype wire

// File: rtl/correlation_frame_tx_byte_sel.sv
`default_nettype none
// ============================================================================
//  Module   : correlation_frame_tx_byte_sel
//  Purpose  : Picks the payload byte addressed by (channel, byte) out of the
//             snapshot register; bytes within a count are sent MSB first.
//  Revision : 1.0  initial release
// ============================================================================
module correlation_frame_tx_byte_sel
  import correlator_pkg::*;
#(
  parameter int NUM_CHANNELS = 66,
  parameter int RESOLUTION   = 16,
  parameter int CH_W         = 7,
  parameter int BI_W         = 1
) (
  input  logic [NUM_CHANNELS*RESOLUTION-1:0] snapshot,
  input  logic [CH_W-1:0]                    ch_idx,
  input  logic [BI_W-1:0]                    byte_idx,
  output logic [7:0]                         data_byte
);

  localparam int BPC = bytes_per_count(RESOLUTION);

  // Constant-index decode keeps every slice static; byte 0 is the top byte.
  always_comb begin
    data_byte = 8'h00;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      for (int b = 0; b < BPC; b++) begin
        if (ch_idx == CH_W'(c) && byte_idx == BI_W'(b)) begin
          data_byte = snapshot[c*RESOLUTION + (BPC-1-b)*8 +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/correlation_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module   : correlation_frame_tx
//  Purpose  : Snapshots the per-baseline coincidence counts on each
//             integration strobe and streams them as a checksummed byte frame
//             (HDR, SEQ, payload MSB first, CSUM) over a valid/ready link.
//  Revision : 1.0  initial release
// ============================================================================
module correlation_frame_tx
  import correlator_pkg::*;
#(
  parameter int         NUM_CHANNELS = 66,
  parameter int         RESOLUTION   = 16,
  parameter logic [7:0] HEADER_BYTE  = DEFAULT_HEADER_BYTE
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               integration_clk_pulse,
  input  logic [NUM_CHANNELS*RESOLUTION-1:0] counts,
  output logic [7:0]                         tx_data,
  output logic                               tx_valid,
  input  logic                               tx_ready,
  output logic                               busy,
  output logic                               overrun,
  output logic [7:0]                         dropped_frames
);

  localparam int BPC  = bytes_per_count(RESOLUTION);
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int BI_W = (BPC > 1) ? $clog2(BPC) : 1;
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CHANNELS - 1);
  localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(BPC - 1);

  frame_state_t state, next_state;

  logic [NUM_CHANNELS*RESOLUTION-1:0] snapshot;
  logic [7:0]      seq_cnt;
  logic [7:0]      csum;
  logic [7:0]      data_byte;
  logic [CH_W-1:0] ch_idx;
  logic [BI_W-1:0] byte_idx;
  logic            handshake;
  logic            accept;
  logic            drop;
  logic            last_data;

  assign tx_valid  = (state != ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign handshake = tx_valid && tx_ready;
  assign last_data = (ch_idx == LAST_CH) && (byte_idx == LAST_BYTE);
  // A strobe landing on the closing CSUM handshake starts the next frame
  // back-to-back instead of being treated as an overrun.
  assign accept    = integration_clk_pulse &&
                     ((state == ST_IDLE) || (state == ST_CSUM && handshake));
  assign drop      = integration_clk_pulse && !accept;

  correlation_frame_tx_byte_sel #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .RESOLUTION   (RESOLUTION),
    .CH_W         (CH_W),
    .BI_W         (BI_W)
  ) u_byte_sel (
    .snapshot  (snapshot),
    .ch_idx    (ch_idx),
    .byte_idx  (byte_idx),
    .data_byte (data_byte)
  );

  // Frame state register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next-state decode and output byte selection; tx_data only moves on a
  // handshake because every source it muxes is held otherwise.
  always_comb begin
    next_state = state;
    tx_data    = 8'h00;
    case (state)
      ST_IDLE: begin
        if (accept) next_state = ST_HDR;
      end
      ST_HDR: begin
        tx_data = HEADER_BYTE;
        if (handshake) next_state = ST_SEQ;
      end
      ST_SEQ: begin
        tx_data = seq_cnt;
        if (handshake) next_state = ST_DATA;
      end
      ST_DATA: begin
        tx_data = data_byte;
        if (handshake && last_data) next_state = ST_CSUM;
      end
      ST_CSUM: begin
        tx_data = csum;
        if (handshake) next_state = accept ? ST_HDR : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Snapshot capture, payload indexing, checksum and sequence numbering.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      snapshot <= '0;
      seq_cnt  <= 8'h00;
      csum     <= 8'h00;
      ch_idx   <= '0;
      byte_idx <= '0;
    end else begin
      if (accept) begin
        snapshot <= counts;
        csum     <= 8'h00;
        ch_idx   <= '0;
        byte_idx <= '0;
      end else if (handshake && (state == ST_SEQ || state == ST_DATA)) begin
        csum <= csum + tx_data;
        if (state == ST_DATA) begin
          if (byte_idx == LAST_BYTE) begin
            byte_idx <= '0;
            ch_idx   <= ch_idx + CH_W'(1);
          end else begin
            byte_idx <= byte_idx + BI_W'(1);
          end
        end
      end
      if (handshake && state == ST_CSUM) seq_cnt <= seq_cnt + 8'd1;
    end
  end

  // Sticky overrun flag and saturating dropped-strobe counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overrun        <= 1'b0;
      dropped_frames <= 8'h00;
    end else if (drop) begin
      overrun <= 1'b1;
      if (dropped_frames != 8'hFF) dropped_frames <= dropped_frames + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_correlation_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_correlation_frame_tx
//  Purpose  : Directed self-checking bench for correlation_frame_tx with two
//             16-bit channels (7-byte frames).
//  Revision : 1.0  initial release
// ============================================================================
module tb_correlation_frame_tx;

  localparam int NCH = 2;
  localparam int RES = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              integration_clk_pulse;
  logic [NCH*RES-1:0] counts;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              overrun;
  logic [7:0]        dropped_frames;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  correlation_frame_tx #(
    .NUM_CHANNELS (NCH),
    .RESOLUTION   (RES),
    .HEADER_BYTE  (8'hA5)
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .integration_clk_pulse (integration_clk_pulse),
    .counts                (counts),
    .tx_data               (tx_data),
    .tx_valid              (tx_valid),
    .tx_ready              (tx_ready),
    .busy                  (busy),
    .overrun               (overrun),
    .dropped_frames        (dropped_frames)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse the strobe for one cycle; header must appear the cycle after.
  task automatic start_frame();
    integration_clk_pulse = 1'b1;
    @(posedge clk); #1;
    integration_clk_pulse = 1'b0;
    check("start_valid", {31'd0, tx_valid}, 32'd1);
    check("start_hdr", {24'd0, tx_data}, 32'hA5);
  endtask

  // Consume one whole frame, checking each byte against a locally built
  // reference. strobe_at = byte index at which to raise the strobe (-1: none).
  task automatic run_frame(input logic [7:0] seq, input logic [15:0] c0,
                           input logic [15:0] c1, input bit bp, input int strobe_at);
    logic [7:0] exp_b [7];
    logic [7:0] held;
    bit         stalled;
    bit         rdy;
    int         idx;
    int         guard;
    exp_b[0] = 8'hA5;
    exp_b[1] = seq;
    exp_b[2] = c0[15:8];
    exp_b[3] = c0[7:0];
    exp_b[4] = c1[15:8];
    exp_b[5] = c1[7:0];
    exp_b[6] = exp_b[1] + exp_b[2] + exp_b[3] + exp_b[4] + exp_b[5];
    idx = 0; guard = 0; stalled = 1'b0; held = 8'h00;
    while (idx < 7 && guard < 500) begin
      if (stalled) check($sformatf("stable%0d", idx), {24'd0, tx_data}, {24'd0, held});
      check($sformatf("valid%0d", idx), {31'd0, tx_valid}, 32'd1);
      rdy = (idx == strobe_at) ? 1'b1 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
      tx_ready = rdy;
      integration_clk_pulse = (idx == strobe_at);
      if (rdy) begin
        check($sformatf("seq%0h_byte%0d", seq, idx), {24'd0, tx_data}, {24'd0, exp_b[idx]});
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = tx_data;
      end
      @(posedge clk); #1;
      integration_clk_pulse = 1'b0;
      guard++;
    end
    tx_ready = 1'b0;
    if (guard >= 500) check("frame_timeout", 32'(guard), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    integration_clk_pulse = 1'b0;
    tx_ready = 1'b1;
    counts = {16'hABCD, 16'h1234};
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_data", {24'd0, tx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_dropped", {24'd0, dropped_frames}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    // ready high while idle must not start anything
    check("idle_valid", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // Basic frame: A5 00 12 34 AB CD BE
    start_frame();
    run_frame(8'h00, 16'h1234, 16'hABCD, 1'b0, -1);
    check("basic_busy_end", {31'd0, busy}, 32'd0);

    // Backpressure
    start_frame();
    run_frame(8'h01, 16'h1234, 16'hABCD, 1'b1, -1);

    // Snapshot isolation: counts change right after the capture
    start_frame();
    counts = '1;
    run_frame(8'h02, 16'h1234, 16'hABCD, 1'b0, -1);
    counts = {16'hABCD, 16'h1234};

    // Overrun: strobe during DATA
    start_frame();
    run_frame(8'h03, 16'h1234, 16'hABCD, 1'b0, 2);
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    check("ovr_dropped1", {24'd0, dropped_frames}, 32'd1);
    check("ovr_idle", {31'd0, busy}, 32'd0);

    // Many dropped strobes while stalled in HDR; seq not bumped by drops
    start_frame();
    tx_ready = 1'b0;
    integration_clk_pulse = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    integration_clk_pulse = 1'b0;
    check("sat_dropped", {24'd0, dropped_frames}, 32'hFF);
    check("sat_overrun", {31'd0, overrun}, 32'd1);
    run_frame(8'h04, 16'h1234, 16'hABCD, 1'b0, -1);

    // Reset mid-frame (in DATA)
    start_frame();
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    tx_ready = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_overrun", {31'd0, overrun}, 32'd0);
    check("mid_rst_dropped", {24'd0, dropped_frames}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_no_tail", {31'd0, tx_valid}, 32'd0);

    // Back-to-back: strobe on the CSUM handshake; next frame uses SEQ=00 then 01
    start_frame();
    run_frame(8'h00, 16'h1234, 16'hABCD, 1'b0, 6);
    check("b2b_valid", {31'd0, tx_valid}, 32'd1);
    check("b2b_hdr", {24'd0, tx_data}, 32'hA5);
    check("b2b_overrun", {31'd0, overrun}, 32'd0);
    run_frame(8'h01, 16'h1234, 16'hABCD, 1'b0, -1);
    check("b2b_end_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
